// File: rtl/fractal_pkg.sv
// Shared types and constants for the multi-lane escape-time engine.
package fractal_pkg;

   localparam int TAG_ITER_W = 16;

   typedef enum logic {
      MODE_MANDEL = 1'b0,
      MODE_JULIA  = 1'b1
   } mode_t;

   typedef enum logic [1:0] {
      LANE_IDLE = 2'd0,
      LANE_ITER = 2'd1,
      LANE_DONE = 2'd2
   } lane_state_t;

   typedef struct packed {
      logic [TAG_ITER_W-1:0] iter;
      logic                  escaped;
      logic                  sof;
      logic                  eol;
   } lane_tag_t;

   // |z|^2 must strictly exceed 4.0 in the lane's fixed-point scale to escape.
   function automatic longint ESC_LIMIT(input int frac_w);
      return longint'(4) << frac_w;
   endfunction

endpackage

// File: rtl/fractal_lane.sv
// One escape-time lane: IDLE -> ITER -> DONE -> IDLE, with fixed-point z/c datapath.
module fractal_lane
   import fractal_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int FRAC_W = 8,
   parameter int ITER_W = 8
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_load,
   input  logic              i_mode,
   input  logic [ITER_W-1:0] i_max_iter,
   input  logic [DATA_W-1:0] i_pix_re,
   input  logic [DATA_W-1:0] i_pix_im,
   input  logic [DATA_W-1:0] i_julia_re,
   input  logic [DATA_W-1:0] i_julia_im,
   input  logic              i_sof,
   input  logic              i_eol,
   input  logic              i_release,
   output logic              o_idle,
   output logic              o_done,
   output logic [ITER_W-1:0] o_iter,
   output logic              o_escaped,
   output logic              o_sof,
   output logic              o_eol
);

   localparam int PW = 2 * DATA_W;
   localparam logic signed [PW:0] C_LIMIT = (PW + 1)'(ESC_LIMIT(FRAC_W));

   lane_state_t              r_state;
   logic signed [DATA_W-1:0] r_zr, r_zi, r_cr, r_ci;
   logic [ITER_W-1:0]        r_iter, r_max_iter;
   lane_tag_t                r_tag;

   logic signed [PW-1:0]     w_prod_rr, w_prod_ii, w_prod_ri, w_zr2, w_zi2, w_cross;
   logic signed [PW:0]       w_mag;
   logic signed [DATA_W-1:0] w_zr_next, w_zi_next;
   logic                     w_esc, w_term;

   // Magnitude is kept at full product width so the escape test never wraps.
   always_comb begin
      w_prod_rr = r_zr * r_zr;
      w_prod_ii = r_zi * r_zi;
      w_prod_ri = r_zr * r_zi;
      w_zr2     = w_prod_rr >>> FRAC_W;
      w_zi2     = w_prod_ii >>> FRAC_W;
      w_cross   = (w_prod_ri <<< 1) >>> FRAC_W;
      w_mag     = {w_zr2[PW-1], w_zr2} + {w_zi2[PW-1], w_zi2};
      w_esc     = w_mag > C_LIMIT;
      w_term    = w_esc || (r_iter == r_max_iter);
      w_zr_next = DATA_W'(w_zr2 - w_zi2) + r_cr;
      w_zi_next = DATA_W'(w_cross) + r_ci;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state    <= LANE_IDLE;
         r_zr       <= '0;
         r_zi       <= '0;
         r_cr       <= '0;
         r_ci       <= '0;
         r_iter     <= '0;
         r_max_iter <= '0;
         r_tag      <= '0;
      end else begin
         case (r_state)
            LANE_IDLE: begin
               if (i_load) begin
                  r_state    <= LANE_ITER;
                  r_iter     <= '0;
                  r_max_iter <= i_max_iter;
                  r_tag      <= '{iter: '0, escaped: 1'b0, sof: i_sof, eol: i_eol};
                  if (mode_t'(i_mode) == MODE_JULIA) begin
                     r_zr <= i_pix_re;
                     r_zi <= i_pix_im;
                     r_cr <= i_julia_re;
                     r_ci <= i_julia_im;
                  end else begin
                     r_zr <= '0;
                     r_zi <= '0;
                     r_cr <= i_pix_re;
                     r_ci <= i_pix_im;
                  end
               end
            end
            LANE_ITER: begin
               if (w_term) begin
                  r_state       <= LANE_DONE;
                  r_tag.iter    <= TAG_ITER_W'(r_iter);
                  r_tag.escaped <= w_esc;
               end else begin
                  r_zr   <= w_zr_next;
                  r_zi   <= w_zi_next;
                  r_iter <= r_iter + ITER_W'(1);
               end
            end
            LANE_DONE: begin
               if (i_release) r_state <= LANE_IDLE;
            end
            default: r_state <= LANE_IDLE;
         endcase
      end
   end

   assign o_idle    = (r_state == LANE_IDLE);
   assign o_done    = (r_state == LANE_DONE);
   assign o_iter    = r_tag.iter[ITER_W-1:0];
   assign o_escaped = r_tag.escaped;
   assign o_sof     = r_tag.sof;
   assign o_eol     = r_tag.eol;

endmodule

// File: rtl/fractal_lane_array.sv
// Round-robin dispatch of raster pixels into NUM_LANES lanes and in-order drain to a valid/ready stream.
module fractal_lane_array
   import fractal_pkg::*;
#(
   parameter int NUM_LANES = 4,
   parameter int DATA_W    = 16,
   parameter int FRAC_W    = 8,
   parameter int ITER_W    = 8,
   parameter int X_SIZE    = 640,
   parameter int Y_SIZE    = 480
) (
   input  logic              out_stream_aclk,
   input  logic              periph_reset,
   input  logic              cfg_mode,
   input  logic [ITER_W-1:0] cfg_max_iter,
   input  logic [DATA_W-1:0] cfg_re_min,
   input  logic [DATA_W-1:0] cfg_im_min,
   input  logic [DATA_W-1:0] cfg_step_re,
   input  logic [DATA_W-1:0] cfg_step_im,
   input  logic [DATA_W-1:0] cfg_julia_re,
   input  logic [DATA_W-1:0] cfg_julia_im,
   output logic [ITER_W-1:0] pix_iter,
   output logic              pix_escaped,
   output logic              pix_sof,
   output logic              pix_eol,
   output logic              pix_valid,
   input  logic              pix_ready
);

   localparam int PTR_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
   localparam int XW    = $clog2(X_SIZE + 1);
   localparam int YW    = $clog2(Y_SIZE + 1);
   localparam logic [PTR_W-1:0] LAST_LANE = PTR_W'(NUM_LANES - 1);
   localparam logic [XW-1:0]    LAST_X    = XW'(X_SIZE - 1);
   localparam logic [YW-1:0]    LAST_Y    = YW'(Y_SIZE - 1);

   logic [PTR_W-1:0]  r_disp_ptr, r_out_ptr;
   logic [XW-1:0]     r_x;
   logic [YW-1:0]     r_y;
   logic [DATA_W-1:0] r_cur_re, r_cur_im;
   logic              r_sh_mode;
   logic [ITER_W-1:0] r_sh_max_iter;
   logic [DATA_W-1:0] r_sh_re_min, r_sh_step_re, r_sh_step_im, r_sh_julia_re, r_sh_julia_im;

   logic              w_first, w_last_x, w_disp, w_valid, w_handshake, w_mode;
   logic [ITER_W-1:0] w_max_iter;
   logic [DATA_W-1:0] w_pix_re, w_pix_im, w_re_min, w_step_re, w_step_im, w_julia_re, w_julia_im;
   logic [NUM_LANES-1:0] w_idle, w_done, w_esc, w_sof, w_eol;
   logic [ITER_W-1:0]    w_iter [NUM_LANES];

   assign w_first  = (r_x == '0) && (r_y == '0);
   assign w_last_x = (r_x == LAST_X);
   assign w_disp   = w_idle[r_disp_ptr];

   // Pixel (0,0) uses live config; the rest of the frame uses the copy captured with it.
   assign w_mode     = w_first ? cfg_mode     : r_sh_mode;
   assign w_max_iter = w_first ? cfg_max_iter : r_sh_max_iter;
   assign w_re_min   = w_first ? cfg_re_min   : r_sh_re_min;
   assign w_step_re  = w_first ? cfg_step_re  : r_sh_step_re;
   assign w_step_im  = w_first ? cfg_step_im  : r_sh_step_im;
   assign w_julia_re = w_first ? cfg_julia_re : r_sh_julia_re;
   assign w_julia_im = w_first ? cfg_julia_im : r_sh_julia_im;
   assign w_pix_re   = w_first ? cfg_re_min   : r_cur_re;
   assign w_pix_im   = w_first ? cfg_im_min   : r_cur_im;

   for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
      fractal_lane #(
         .DATA_W (DATA_W),
         .FRAC_W (FRAC_W),
         .ITER_W (ITER_W)
      ) u_lane (
         .i_clk      (out_stream_aclk),
         .i_rst      (periph_reset),
         .i_load     (w_disp && (r_disp_ptr == PTR_W'(g))),
         .i_mode     (w_mode),
         .i_max_iter (w_max_iter),
         .i_pix_re   (w_pix_re),
         .i_pix_im   (w_pix_im),
         .i_julia_re (w_julia_re),
         .i_julia_im (w_julia_im),
         .i_sof      (w_first),
         .i_eol      (w_last_x),
         .i_release  (w_handshake && (r_out_ptr == PTR_W'(g))),
         .o_idle     (w_idle[g]),
         .o_done     (w_done[g]),
         .o_iter     (w_iter[g]),
         .o_escaped  (w_esc[g]),
         .o_sof      (w_sof[g]),
         .o_eol      (w_eol[g])
      );
   end

   always_ff @(posedge out_stream_aclk) begin
      if (periph_reset) begin
         r_disp_ptr    <= '0;
         r_x           <= '0;
         r_y           <= '0;
         r_cur_re      <= '0;
         r_cur_im      <= '0;
         r_sh_mode     <= 1'b0;
         r_sh_max_iter <= '0;
         r_sh_re_min   <= '0;
         r_sh_step_re  <= '0;
         r_sh_step_im  <= '0;
         r_sh_julia_re <= '0;
         r_sh_julia_im <= '0;
      end else if (w_disp) begin
         r_disp_ptr <= (r_disp_ptr == LAST_LANE) ? '0 : r_disp_ptr + PTR_W'(1);
         if (w_last_x) begin
            r_x      <= '0;
            r_cur_re <= w_re_min;
            r_cur_im <= w_pix_im + w_step_im;
            r_y      <= (r_y == LAST_Y) ? '0 : r_y + YW'(1);
         end else begin
            r_x      <= r_x + XW'(1);
            r_cur_re <= w_pix_re + w_step_re;
            r_cur_im <= w_pix_im;
         end
         if (w_first) begin
            r_sh_mode     <= cfg_mode;
            r_sh_max_iter <= cfg_max_iter;
            r_sh_re_min   <= cfg_re_min;
            r_sh_step_re  <= cfg_step_re;
            r_sh_step_im  <= cfg_step_im;
            r_sh_julia_re <= cfg_julia_re;
            r_sh_julia_im <= cfg_julia_im;
         end
      end
   end

   always_ff @(posedge out_stream_aclk) begin
      if (periph_reset) begin
         r_out_ptr <= '0;
      end else if (w_handshake) begin
         r_out_ptr <= (r_out_ptr == LAST_LANE) ? '0 : r_out_ptr + PTR_W'(1);
      end
   end

   assign w_valid     = w_done[r_out_ptr];
   assign w_handshake = w_valid && pix_ready;
   assign pix_valid   = w_valid;
   assign pix_iter    = w_valid ? w_iter[r_out_ptr] : '0;
   assign pix_escaped = w_valid && w_esc[r_out_ptr];
   assign pix_sof     = w_valid && w_sof[r_out_ptr];
   assign pix_eol     = w_valid && w_eol[r_out_ptr];

endmodule

// File: tb/tb_fractal_lane_array.sv
// Randomised-backpressure bench comparing the pixel stream to an escape-time reference model.
`timescale 1ns/1ps
module tb_fractal_lane_array;

   localparam int NL  = 3;
   localparam int DW  = 16;
   localparam int FW  = 8;
   localparam int IW  = 8;
   localparam int XS  = 8;
   localparam int YS  = 2;
   localparam int PIX = XS * YS;

   typedef struct {
      logic          mode;
      logic [IW-1:0] maxIter;
      logic [DW-1:0] reMin, imMin, stepRe, stepIm, jRe, jIm;
   } cfg_t;

   logic          clk;
   logic          periph_reset;
   logic          pix_ready;
   logic [IW-1:0] pix_iter;
   logic          pix_escaped, pix_sof, pix_eol, pix_valid;

   cfg_t liveCfg;
   cfg_t frameCfg [0:63];
   int   consumed;
   int   checkCount;
   int   passCount;
   int   readyMode;

   fractal_lane_array #(
      .NUM_LANES (NL), .DATA_W (DW), .FRAC_W (FW), .ITER_W (IW), .X_SIZE (XS), .Y_SIZE (YS)
   ) dut (
      .out_stream_aclk (clk),
      .periph_reset    (periph_reset),
      .cfg_mode        (liveCfg.mode),
      .cfg_max_iter    (liveCfg.maxIter),
      .cfg_re_min      (liveCfg.reMin),
      .cfg_im_min      (liveCfg.imMin),
      .cfg_step_re     (liveCfg.stepRe),
      .cfg_step_im     (liveCfg.stepIm),
      .cfg_julia_re    (liveCfg.jRe),
      .cfg_julia_im    (liveCfg.jIm),
      .pix_iter        (pix_iter),
      .pix_escaped     (pix_escaped),
      .pix_sof         (pix_sof),
      .pix_eol         (pix_eol),
      .pix_valid       (pix_valid),
      .pix_ready       (pix_ready)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic longint wrap16(input longint v);
      logic signed [DW-1:0] t;
      t = v[DW-1:0];
      return longint'(t);
   endfunction

   // Escape-time result for pixel (x,y) of a frame using config c, in plain integer arithmetic.
   function automatic void refPixel(input cfg_t c, input int x, input int y,
                                    output int iter, output bit esc);
      longint pre, pim, zr, zi, cr, ci, zr2, zi2, nzr;
      pre = wrap16(longint'($signed(c.reMin)) + longint'(x) * longint'($signed(c.stepRe)));
      pim = wrap16(longint'($signed(c.imMin)) + longint'(y) * longint'($signed(c.stepIm)));
      if (c.mode) begin
         zr = pre; zi = pim;
         cr = longint'($signed(c.jRe)); ci = longint'($signed(c.jIm));
      end else begin
         zr = 0; zi = 0; cr = pre; ci = pim;
      end
      iter = 0;
      esc  = 0;
      for (int k = 0; k <= 256; k++) begin
         zr2 = (zr * zr) >>> FW;
         zi2 = (zi * zi) >>> FW;
         if (zr2 + zi2 > (longint'(4) << FW)) begin
            esc = 1;
            return;
         end
         if (iter == int'(c.maxIter)) return;
         nzr  = wrap16(zr2 - zi2 + cr);
         zi   = wrap16(((2 * zr * zi) >>> FW) + ci);
         zr   = nzr;
         iter = iter + 1;
      end
   endfunction

   task automatic checkOutput(input string name, input longint actual, input longint expected);
      checkCount++;
      if (actual == expected) passCount++;
      else $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
   endtask

   task automatic applyStimulus(input cfg_t c, input int fromFrame);
      liveCfg = c;
      for (int k = fromFrame; k < 64; k++) frameCfg[k] = c;
   endtask

   task automatic waitConsumed(input int target);
      int n;
      n = 0;
      while (consumed < target && n < 4000) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (consumed < target) checkOutput("progress", consumed, target);
   endtask

   initial begin : readyProc
      pix_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (readyMode == 1)      pix_ready = 1'b0;
         else if (readyMode == 2) pix_ready = 1'b1;
         else                     pix_ready = ($urandom_range(0, 3) != 0);
      end
   end

   initial begin : compareProc
      int  it, p, f, x, y;
      bit  esc, prevValid, prevReady, justReset;
      prevValid = 0;
      prevReady = 0;
      justReset = 0;
      forever begin
         @(negedge clk);
         if (periph_reset) begin
            consumed  = 0;
            justReset = 1;
            prevValid = 0;
            continue;
         end
         if (justReset) begin
            checkOutput("valid_after_reset", pix_valid, 0);
            justReset = 0;
         end
         if (prevValid && !prevReady) checkOutput("hold_valid", pix_valid, 1);
         if (pix_valid) begin
            p = consumed % PIX;
            f = consumed / PIX;
            x = p % XS;
            y = p / XS;
            refPixel(frameCfg[f], x, y, it, esc);
            checkOutput("iter", pix_iter, it);
            checkOutput("escaped", pix_escaped, esc);
            checkOutput("sof", pix_sof, (p == 0));
            checkOutput("eol", pix_eol, (x == XS - 1));
            if (pix_ready) consumed++;
         end
         prevValid = pix_valid;
         prevReady = pix_ready;
      end
   end

   initial begin : mainProc
      int   it, n;
      bit   esc;
      cfg_t cA, cB, cC, cD, cE;
      checkCount   = 0;
      passCount    = 0;
      readyMode    = 2;
      periph_reset = 1'b1;

      cA = '{mode: 1'b0, maxIter: 8'd20, reMin: 16'h0000, imMin: 16'h0000,
             stepRe: 16'h0000, stepIm: 16'h0000, jRe: 16'h0000, jIm: 16'h0000};
      cB = '{mode: 1'b0, maxIter: 8'd20, reMin: 16'h0200, imMin: 16'h0000,
             stepRe: 16'h0000, stepIm: 16'h0000, jRe: 16'h0000, jIm: 16'h0000};
      cC = '{mode: 1'b0, maxIter: 8'd30, reMin: 16'hFE00, imMin: 16'hFF40,
             stepRe: 16'h0060, stepIm: 16'h00C0, jRe: 16'h0000, jIm: 16'h0000};
      cD = '{mode: 1'b1, maxIter: 8'd15, reMin: 16'hFE80, imMin: 16'hFFC0,
             stepRe: 16'h0060, stepIm: 16'h0080, jRe: 16'hFF33, jIm: 16'h0028};
      cE = '{mode: 1'b1, maxIter: 8'd0, reMin: 16'hFD00, imMin: 16'h0000,
             stepRe: 16'h00C0, stepIm: 16'h0100, jRe: 16'h0000, jIm: 16'h0000};

      // Hand-computed anchors for the reference model.
      refPixel(cA, 3, 1, it, esc);
      checkOutput("pin_cap_iter", it, 20);
      checkOutput("pin_cap_esc", esc, 0);
      refPixel(cB, 0, 0, it, esc);
      checkOutput("pin_two_iter", it, 2);
      checkOutput("pin_two_esc", esc, 1);
      refPixel(cE, 0, 0, it, esc);
      checkOutput("pin_zero_out_iter", it, 0);
      checkOutput("pin_zero_out_esc", esc, 1);
      refPixel(cE, 4, 0, it, esc);
      checkOutput("pin_zero_in_iter", it, 0);
      checkOutput("pin_zero_in_esc", esc, 0);

      applyStimulus(cA, 0);
      repeat (3) @(posedge clk);
      #1;
      periph_reset = 1'b0;
      readyMode    = 0;

      waitConsumed(4);
      applyStimulus(cB, 1);
      waitConsumed(PIX + 4);
      applyStimulus(cC, 2);

      waitConsumed(2 * PIX + 2);
      n = 0;
      while (!pix_valid && n < 500) begin
         @(negedge clk);
         n++;
      end
      readyMode = 1;
      repeat (50) @(posedge clk);
      #1;
      checkOutput("stall_valid", pix_valid, 1);
      readyMode = 0;

      waitConsumed(2 * PIX + 8);
      applyStimulus(cD, 3);
      waitConsumed(3 * PIX + 4);
      applyStimulus(cE, 4);

      waitConsumed(4 * PIX + 6);
      applyStimulus(liveCfg, 0);
      periph_reset = 1'b1;
      @(posedge clk);
      #1;
      periph_reset = 1'b0;

      waitConsumed(4);
      applyStimulus(cC, 1);
      waitConsumed(2 * PIX);
      readyMode = 2;
      repeat (5) @(posedge clk);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
